// File: rtl/tt_out_arbiter.sv
// Round-robin scheduler for the shared io_out pad bus: one source owns the bus at a time,
// its words are registered onto out_data, and ownership is released on last, dropped req or hold limit.
module tt_out_arbiter #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   data,
   input  logic [N_REQ-1:0]          last,
   output logic [N_REQ-1:0]          grant,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   output logic                      busy
);

   localparam int PTR_W = $clog2(N_REQ);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   ptr, ptr_nxt;
   logic [PTR_W-1:0]   owner, owner_nxt;
   logic [PTR_W-1:0]   pick;
   logic               pick_ok;
   logic [PTR_W:0]     scan_idx;
   logic [7:0]         hold_cnt, hold_nxt;
   logic [N_REQ-1:0]   grant_nxt;
   logic [DATA_W-1:0]  data_nxt;
   logic               valid_nxt;
   logic [PTR_W-1:0]   owner_inc;
   logic [DATA_W-1:0]  words [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_words
      assign words[g] = data[g*DATA_W +: DATA_W];
   end

   assign owner_inc = (owner == PTR_W'(N_REQ-1)) ? '0 : owner + 1'b1;

   // Scan from the farthest offset down so the set bit nearest to ptr wins.
   always_comb begin
      pick     = '0;
      pick_ok  = 1'b0;
      scan_idx = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         scan_idx = {1'b0, ptr} + (PTR_W+1)'(i);
         if (scan_idx >= (PTR_W+1)'(N_REQ))
            scan_idx = scan_idx - (PTR_W+1)'(N_REQ);
         if (req[scan_idx[PTR_W-1:0]]) begin
            pick    = scan_idx[PTR_W-1:0];
            pick_ok = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      hold_nxt  = hold_cnt;
      grant_nxt = grant;
      data_nxt  = out_data;
      valid_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (pick_ok) begin
               owner_nxt       = pick;
               grant_nxt       = '0;
               grant_nxt[pick] = 1'b1;
               hold_nxt        = '0;
               state_nxt       = GRANT;
            end
         end
         GRANT: begin
            // A dropped request releases without a transfer; last and the hold limit release after one.
            if (req[owner]) begin
               data_nxt  = words[owner];
               valid_nxt = 1'b1;
               hold_nxt  = hold_cnt + 8'd1;
               if (last[owner] || (hold_cnt == 8'(MAX_HOLD-1))) begin
                  grant_nxt = '0;
                  state_nxt = IDLE;
                  ptr_nxt   = owner_inc;
                  hold_nxt  = '0;
               end
            end else begin
               grant_nxt = '0;
               state_nxt = IDLE;
               ptr_nxt   = owner_inc;
               hold_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         hold_cnt  <= '0;
         grant     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         owner     <= owner_nxt;
         hold_cnt  <= hold_nxt;
         grant     <= grant_nxt;
         out_data  <= data_nxt;
         out_valid <= valid_nxt;
         busy      <= (state_nxt == GRANT);
      end
   end

endmodule

// File: tb/tb_tt_out_arbiter.sv
// Bench for tt_out_arbiter: two instances (hold limits 16 and 2) share stimulus and are compared
// against a transaction-level reference model plus directed expectations for each scenario.
module tb_tt_out_arbiter;

   localparam int N      = 4;
   localparam int HOLD_A = 16;
   localparam int HOLD_B = 2;

   logic             clk   = 1'b0;
   logic             reset = 1'b0;
   logic [N-1:0]     req   = '0;
   logic [N-1:0]     last  = '0;
   logic [N*8-1:0]   data  = '0;
   logic [N-1:0]     grant_a, grant_b;
   logic [7:0]       data_a, data_b;
   logic             valid_a, valid_b, busy_a, busy_b;
   logic [13:0]      obs [2];
   int               errors = 0;
   int               checks = 0;

   typedef struct {
      int         owner;
      int         ptr;
      int         cnt;
      logic       valid;
      logic [7:0] dat;
   } mstate_t;

   mstate_t m [2];

   always #5 clk = ~clk;

   tt_out_arbiter #(.N_REQ(N), .DATA_W(8), .MAX_HOLD(HOLD_A)) u_a (
      .clk(clk), .reset(reset), .req(req), .data(data), .last(last),
      .grant(grant_a), .out_data(data_a), .out_valid(valid_a), .busy(busy_a)
   );

   tt_out_arbiter #(.N_REQ(N), .DATA_W(8), .MAX_HOLD(HOLD_B)) u_b (
      .clk(clk), .reset(reset), .req(req), .data(data), .last(last),
      .grant(grant_b), .out_data(data_b), .out_valid(valid_b), .busy(busy_b)
   );

   assign obs[0] = {grant_a, busy_a, valid_a, data_a};
   assign obs[1] = {grant_b, busy_b, valid_b, data_b};

   // Reference: owner < 0 means the bus is free; one call advances one clock edge.
   function automatic mstate_t model_next(input int lim, input mstate_t s);
      mstate_t n;
      int      idx;
      n = s;
      if (s.owner < 0) begin
         n.valid = 1'b0;
         for (int i = 0; i < N; i++) begin
            idx = (s.ptr + i) % N;
            if (n.owner < 0 && req[idx]) begin
               n.owner = idx;
               n.cnt   = 0;
            end
         end
      end else if (req[s.owner]) begin
         n.dat   = data[s.owner*8 +: 8];
         n.valid = 1'b1;
         n.cnt   = s.cnt + 1;
         if (last[s.owner] || n.cnt == lim) begin
            n.owner = -1;
            n.ptr   = (s.owner + 1) % N;
            n.cnt   = 0;
         end
      end else begin
         n.valid = 1'b0;
         n.owner = -1;
         n.ptr   = (s.owner + 1) % N;
         n.cnt   = 0;
      end
      return n;
   endfunction

   function automatic logic [13:0] exp_vec(input mstate_t s);
      logic [3:0] g;
      g = (s.owner >= 0) ? 4'(1 << s.owner) : 4'b0000;
      return {g, (s.owner >= 0), s.valid, s.dat};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m[0] <= '{owner: -1, ptr: 0, cnt: 0, valid: 1'b0, dat: 8'h00};
         m[1] <= '{owner: -1, ptr: 0, cnt: 0, valid: 1'b0, dat: 8'h00};
      end else begin
         m[0] <= model_next(HOLD_A, m[0]);
         m[1] <= model_next(HOLD_B, m[1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = '0;
      last  = '0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic go_idle();
      req  = '0;
      last = '0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++;
      if ({grant_a, valid_a, busy_a, data_a} !== 14'h0) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h expected %h", {grant_a, valid_a, busy_a, data_a}, 14'h0);
      end
      reset = 1'b0;
      req   = 4'b0100;
      data  = $urandom;
      tick();
      checks++;
      if (grant_a !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL first_grant: grant=%b expected 0100", grant_a);
      end
      tick();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({grant_a, valid_a, busy_a, grant_b, valid_b, busy_b} !== 12'h0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h expected 000",
                  {grant_a, valid_a, busy_a, grant_b, valid_b, busy_b});
      end
      #2;
      reset = 1'b0;
      tick();
      checks++;
      if (grant_a !== 4'b0100 || grant_b !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL regrant_after_reset: grant_a=%b grant_b=%b expected 0100", grant_a, grant_b);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs[k] !== exp_vec(m[k])) begin
            errors++;
            $display("[TB] FAIL reset_model_%0d: got %h expected %h", k, obs[k], exp_vec(m[k]));
         end
      end
      go_idle();
   endtask

   task automatic test_single_source();
      logic [3:0] eg [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
      logic       ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         req  = (c == 4) ? 4'b0011 : 4'b0001;
         last = (c == 3) ? 4'b0001 : 4'b0000;
         data = {24'($urandom), 8'hA5};
         tick();
         checks++;
         if (grant_a !== eg[c] || valid_a !== ev[c] || (ev[c] && data_a !== 8'hA5)) begin
            errors++;
            $display("[TB] FAIL single_source c%0d: grant=%b valid=%b data=%h expected %b %b A5",
                     c, grant_a, valid_a, data_a, eg[c], ev[c]);
         end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(m[k])) begin
               errors++;
               $display("[TB] FAIL single_model_%0d c%0d: got %h expected %h", k, c, obs[k], exp_vec(m[k]));
            end
         end
      end
      go_idle();
   endtask

   task automatic test_round_robin();
      logic [3:0] eg;
      logic       ev;
      int         p;
      do_reset();
      req = 4'b1111;
      for (int e = 1; e <= 13; e++) begin
         data = $urandom;
         tick();
         p  = (e - 1) % 3;
         eg = (p == 2) ? 4'b0000 : 4'(1 << (((e - 1) / 3) % 4));
         ev = (p != 0);
         checks++;
         if (grant_b !== eg || valid_b !== ev) begin
            errors++;
            $display("[TB] FAIL round_robin e%0d: grant=%b valid=%b expected %b %b", e, grant_b, valid_b, eg, ev);
         end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(m[k])) begin
               errors++;
               $display("[TB] FAIL rr_model_%0d e%0d: got %h expected %h", k, e, obs[k], exp_vec(m[k]));
            end
         end
      end
      go_idle();
   endtask

   task automatic test_hold_limit();
      int nvalid = 0;
      do_reset();
      req = 4'b1000;
      for (int e = 1; e <= 18; e++) begin
         data = $urandom;
         tick();
         if (valid_a) nvalid++;
         if (e == 1 || e == 17 || e == 18) begin
            checks++;
            if (grant_a !== ((e == 17) ? 4'b0000 : 4'b1000) || (e >= 17 && valid_a !== (e == 17))) begin
               errors++;
               $display("[TB] FAIL hold_limit e%0d: grant=%b valid=%b", e, grant_a, valid_a);
            end
         end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(m[k])) begin
               errors++;
               $display("[TB] FAIL hold_model_%0d e%0d: got %h expected %h", k, e, obs[k], exp_vec(m[k]));
            end
         end
      end
      checks++;
      if (nvalid != HOLD_A) begin
         errors++;
         $display("[TB] FAIL hold_count: valid cycles=%0d expected %0d", nvalid, HOLD_A);
      end
      go_idle();
   endtask

   task automatic test_dropped_request();
      int         nvalid = 0;
      logic [7:0] saved  = 8'h00;
      do_reset();
      for (int e = 1; e <= 8; e++) begin
         req  = (e == 1) ? 4'b0010 : (e <= 6) ? 4'b0011 : 4'b0001;
         data = $urandom;
         if (e == 6) saved = data[15:8];
         tick();
         if (valid_a) nvalid++;
         if (e == 1 || e >= 6) begin
            checks++;
            if ((e == 1 && grant_a !== 4'b0010) ||
                (e == 6 && (valid_a !== 1'b1 || data_a !== saved)) ||
                (e == 7 && (grant_a !== 4'b0000 || valid_a !== 1'b0 || data_a !== saved)) ||
                (e == 8 && grant_a !== 4'b0001)) begin
               errors++;
               $display("[TB] FAIL dropped_req e%0d: grant=%b valid=%b data=%h saved=%h",
                        e, grant_a, valid_a, data_a, saved);
            end
         end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(m[k])) begin
               errors++;
               $display("[TB] FAIL drop_model_%0d e%0d: got %h expected %h", k, e, obs[k], exp_vec(m[k]));
            end
         end
      end
      checks++;
      if (nvalid != 5) begin
         errors++;
         $display("[TB] FAIL drop_count: valid cycles=%0d expected 5", nvalid);
      end
      go_idle();
   endtask

   task automatic test_ignored_inputs();
      int nvalid = 0;
      do_reset();
      for (int e = 1; e <= 17; e++) begin
         req  = {1'($urandom), 3'b001};
         last = {1'b0, 1'($urandom), 2'b00};
         data = $urandom;
         tick();
         if (valid_a) nvalid++;
         checks++;
         if (grant_a !== ((e <= 16) ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("[TB] FAIL ignored_inputs e%0d: grant=%b", e, grant_a);
         end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(m[k])) begin
               errors++;
               $display("[TB] FAIL ignore_model_%0d e%0d: got %h expected %h", k, e, obs[k], exp_vec(m[k]));
            end
         end
      end
      checks++;
      if (nvalid != HOLD_A) begin
         errors++;
         $display("[TB] FAIL ignored_count: valid cycles=%0d expected %0d", nvalid, HOLD_A);
      end
      go_idle();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            req[i]  = ($urandom_range(0, 9) < 7);
            last[i] = ($urandom_range(0, 9) < 2);
         end
         data = $urandom;
         tick();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(m[k])) begin
               errors++;
               $display("[TB] FAIL random_model_%0d c%0d: got %h expected %h", k, c, obs[k], exp_vec(m[k]));
            end
         end
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b1;
            #2;
            reset = 1'b0;
         end
      end
      go_idle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_source();
      test_round_robin();
      test_hold_limit();
      test_dropped_request();
      test_ignored_inputs();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
